// File: rtl/xor_crc_engine.sv
// Framed CRC/LFSR engine: absorbs DATA_W-bit words MSB-first, pulses out_valid with the final CRC.
// Latency 1 cycle after the last accepted word; in_ready drops only for the single DONE cycle.
module xor_crc_engine #(
  parameter int                WIDTH  = 8,
  parameter logic [WIDTH-1:0]  POLY   = 8'h07,
  parameter logic [WIDTH-1:0]  INIT   = 8'h00,
  parameter logic [WIDTH-1:0]  XOROUT = 8'h00,
  parameter int                DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              last,
  output logic              in_ready,
  output logic              busy,
  output logic              out_valid,
  output logic [WIDTH-1:0]  crc_out,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   crc_q;
  logic [WIDTH-1:0]   crc_out_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               out_valid_q;
  logic               err_q;

  logic               accept;
  logic [WIDTH-1:0]   crc_d;

  function automatic logic [WIDTH-1:0] absorb(input logic [WIDTH-1:0] r_in,
                                              input logic [DATA_W-1:0] d);
    logic [WIDTH-1:0] r;
    logic             fb;
    r = r_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[WIDTH-1] ^ d[i];
      r  = {r[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  // A start word is absorbed on top of INIT, not on top of the running register.
  always_comb begin
    accept = in_valid && in_ready_q && ((state_q == S_ACCUM) || start);
    crc_d  = absorb(start ? INIT : crc_q, in_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      crc_q       <= INIT;
      crc_out_q   <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        S_IDLE, S_ACCUM: begin
          if (start) begin
            crc_q <= accept ? crc_d : INIT;
          end else if (accept) begin
            crc_q <= crc_d;
          end
          if (start && (state_q == S_ACCUM)) begin
            err_q <= 1'b1;
          end
          if (accept && last) begin
            state_q     <= S_DONE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            crc_out_q   <= crc_d ^ XOROUT;
          end else if (start || (state_q == S_ACCUM)) begin
            state_q <= S_ACCUM;
            busy_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign crc_out   = crc_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_xor_crc_engine.sv
// Directed bench for xor_crc_engine in its CRC-8/SMBUS configuration.
module tb_xor_crc_engine;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, last;
  logic [7:0] in_data;
  logic       in_ready, busy, out_valid, err;
  logic [7:0] crc_out;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int err_cnt = 0;
  logic [7:0] last_crc = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic [7:0] crc;
  } vec_t;
  vec_t vecs[5];

  xor_crc_engine #(
    .WIDTH(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00), .DATA_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .last(last), .in_ready(in_ready), .busy(busy), .out_valid(out_valid),
    .crc_out(crc_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge; pulses are tallied here.
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid) begin
      ov_cnt++;
      last_crc = crc_out;
    end
    if (err) err_cnt++;
  endtask

  task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic l);
    start = s; in_valid = v; in_data = d; last = l;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_counts();
    ov_cnt = 0; err_cnt = 0; last_crc = 8'h00;
  endtask

  // "123456789" with up to gap_max idle cycles (last toggling, in_valid low) between words.
  task automatic frame_123456789(input int gap_max);
    drive(1'b1, 1'b1, 8'h31, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      int g;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      for (int j = 0; j < g; j++) drive(1'b0, 1'b0, 8'($urandom), 1'($urandom));
      drive(1'b0, 1'b1, 8'h31 + 8'(k), (k == 8));
    end
  endtask

  task automatic check_frame(input string name, input int exp_err);
    chk({name, "_ov_count"}, ov_cnt, 1);
    chk({name, "_crc"}, {24'h0, last_crc}, 32'hF4);
    chk({name, "_err_count"}, err_cnt, exp_err);
    chk({name, "_busy_after"}, {31'h0, busy}, 0);
    chk({name, "_ready_after"}, {31'h0, in_ready}, 1);
  endtask

  initial begin
    vecs[0] = '{data: 8'h01, crc: 8'h07};
    vecs[1] = '{data: 8'h00, crc: 8'h00};
    vecs[2] = '{data: 8'h02, crc: 8'h0E};
    vecs[3] = '{data: 8'h80, crc: 8'h89};
    vecs[4] = '{data: 8'hFF, crc: 8'hF3};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; last = 1'b0;

    // Reset held two cycles under random inputs.
    for (int c = 0; c < 2; c++) begin
      start = 1'($urandom); in_valid = 1'($urandom); in_data = 8'($urandom); last = 1'($urandom);
      tick();
    end
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_crc_out", {24'h0, crc_out}, 0);
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    rst = 1'b0;
    idle();
    clear_counts();

    // Consecutive frame.
    frame_123456789(0);
    chk("f2_out_valid", {31'h0, out_valid}, 1);
    chk("f2_in_ready_done", {31'h0, in_ready}, 0);
    idle();
    chk("f2_ov_drop", {31'h0, out_valid}, 0);
    check_frame("f2", 0);

    // Single-cycle frames from the table; the DONE cycle gets a start word that must be ignored.
    for (int n = 0; n < 5; n++) begin
      clear_counts();
      drive(1'b1, 1'b1, vecs[n].data, 1'b1);
      chk($sformatf("sc%0d_out_valid", n), {31'h0, out_valid}, 1);
      chk($sformatf("sc%0d_crc", n), {24'h0, crc_out}, {24'h0, vecs[n].crc});
      drive(1'b1, 1'b1, 8'h55, 1'b1);
      chk($sformatf("sc%0d_done_exit_busy", n), {31'h0, busy}, 0);
      chk($sformatf("sc%0d_done_exit_ov", n), {31'h0, out_valid}, 0);
      idle();
      chk($sformatf("sc%0d_ov_count", n), ov_cnt, 1);
      chk($sformatf("sc%0d_crc_held", n), {24'h0, crc_out}, {24'h0, vecs[n].crc});
    end

    // Restart inside an open frame.
    clear_counts();
    drive(1'b1, 1'b1, 8'h31, 1'b0);
    drive(1'b0, 1'b1, 8'h32, 1'b0);
    drive(1'b1, 1'b1, 8'h31, 1'b0);
    chk("abort_err_pulse", {31'h0, err}, 1);
    chk("abort_busy", {31'h0, busy}, 1);
    drive(1'b0, 1'b1, 8'h32, 1'b0);
    chk("abort_err_drop", {31'h0, err}, 0);
    for (int k = 3; k <= 9; k++) drive(1'b0, 1'b1, 8'h30 + 8'(k), (k == 9));
    idle();
    check_frame("abort", 1);

    // IDLE noise followed by a gapped frame.
    clear_counts();
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b1, 8'($urandom), 1'($urandom));
    chk("idle_noise_busy", {31'h0, busy}, 0);
    chk("idle_noise_ov", ov_cnt, 0);
    frame_123456789(3);
    idle();
    check_frame("gap", 0);

    // Reset mid-frame discards it silently.
    clear_counts();
    drive(1'b1, 1'b1, 8'h31, 1'b0);
    for (int k = 2; k <= 4; k++) drive(1'b0, 1'b1, 8'h30 + 8'(k), 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'h35, 1'b1);
    rst = 1'b0;
    idle();
    idle();
    chk("midrst_ov", ov_cnt, 0);
    chk("midrst_err", err_cnt, 0);
    chk("midrst_busy", {31'h0, busy}, 0);
    frame_123456789(0);
    idle();
    check_frame("post_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
